// File: rtl/temp_pkg.sv
// Shared parameters and types for the sequential temperature averaging path.
// Imported by the interface, the divider and the scan controller.
package temp_pkg;

  localparam int N_SENSORS = 5;
  localparam int DATA_W    = 8;
  localparam int TEMP_MIN  = 19;
  localparam int TEMP_MAX  = 26;
  localparam int SUM_W     = 16;
  localparam int CNT_W     = 8;
  localparam int IDX_W     = $clog2(N_SENSORS);
  localparam int BUS_W     = N_SENSORS * DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DIV,
    FIN
  } state_e;

  function automatic logic [DATA_W-1:0] pick(
    input logic [BUS_W-1:0] d,
    input logic [IDX_W-1:0] i
  );
    return d[DATA_W*i +: DATA_W];
  endfunction

endpackage

// File: rtl/temperature_scan_ctrl_if.sv
// Request/result bundle between a measurement requester and the
// temperature scan controller.
interface temperature_scan_ctrl_if;
  import temp_pkg::*;

  logic                 start_i;
  logic [BUS_W-1:0]     sensors_data_i;
  logic [N_SENSORS-1:0] sensors_en_i;
  logic                 busy_o;
  logic                 done_o;
  logic [7:0]           led_output_o;
  logic                 alert_o;

  modport master (
    output start_i,
    output sensors_data_i,
    output sensors_en_i,
    input  busy_o,
    input  done_o,
    input  led_output_o,
    input  alert_o
  );

  modport slave (
    input  start_i,
    input  sensors_data_i,
    input  sensors_en_i,
    output busy_o,
    output done_o,
    output led_output_o,
    output alert_o
  );

endinterface

// File: rtl/temperature_scan_ctrl_divider.sv
// 16-bit restoring divider, one quotient bit per cycle, MSB first.
// Result is valid once ready_o rises, 16 cycles after load_i.
module seq_divider
  import temp_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [SUM_W-1:0] divisor_i,
  output logic [SUM_W-1:0] quotient_o,
  output logic [SUM_W-1:0] remainder_o,
  output logic             ready_o
);

  logic [SUM_W-1:0] quot_q, quot_d;
  logic [SUM_W-1:0] rem_q, rem_d;
  logic [SUM_W-1:0] dvs_q;
  logic [4:0]       cnt_q;

  logic [SUM_W:0] shifted;
  logic [SUM_W:0] trial;

  always_comb begin
    shifted = {rem_q, quot_q[SUM_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    quot_d  = {quot_q[SUM_W-2:0], 1'b0};
    rem_d   = shifted[SUM_W-1:0];
    // No borrow means the divisor fits: keep the difference.
    if (!trial[SUM_W]) begin
      quot_d[0] = 1'b1;
      rem_d     = trial[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= 5'd16;
    end else if (cnt_q != 5'd0) begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign ready_o     = (cnt_q == 5'd0);

endmodule

// File: rtl/temperature_scan_ctrl.sv
// Snapshot-and-scan averaging controller: accumulates enabled readings,
// divides on a shared sequential divider, rounds and flags out-of-range.
module temperature_scan_ctrl
  import temp_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  temperature_scan_ctrl_if.slave bus
);

  state_e               state_q;
  logic [BUS_W-1:0]     data_q;
  logic [N_SENSORS-1:0] en_q;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q;
  logic [3:0]           step_q;
  logic                 busy_q;
  logic                 done_q;
  logic [7:0]           led_q;
  logic                 alert_q;

  logic             last_idx;
  logic             div_load;
  logic [SUM_W-1:0] quot;
  logic [SUM_W-1:0] rem;
  logic             div_ready;
  logic [SUM_W:0]   rem2;
  logic             round_up;
  logic [SUM_W-1:0] avg_d;
  logic             alert_d;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (en_q[idx_q]) begin
      sum_d = sum_q + SUM_W'(pick(data_q, idx_q));
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign last_idx = (idx_q == IDX_W'(N_SENSORS - 1));
  // Divider is loaded on the last scan edge so DIV is exactly 16 edges.
  assign div_load = (state_q == SCAN) && last_idx && (cnt_d != '0);

  seq_divider u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (div_load),
    .dividend_i  (sum_d),
    .divisor_i   (SUM_W'(cnt_d)),
    .quotient_o  (quot),
    .remainder_o (rem),
    .ready_o     (div_ready)
  );

  always_comb begin
    rem2     = {rem, 1'b0};
    round_up = (rem2 >= (SUM_W+1)'(cnt_q));
    avg_d    = quot + SUM_W'(round_up);
    alert_d  = (avg_d < SUM_W'(TEMP_MIN))
             | (avg_d > SUM_W'(TEMP_MAX));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      en_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      led_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            data_q  <= bus.sensors_data_i;
            en_q    <= bus.sensors_en_i;
            sum_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          sum_q <= sum_d;
          cnt_q <= cnt_d;
          idx_q <= idx_q + IDX_W'(1);
          if (last_idx) begin
            idx_q   <= '0;
            step_q  <= '0;
            state_q <= (cnt_d != '0) ? DIV : FIN;
          end
        end
        DIV: begin
          step_q <= step_q + 4'd1;
          if (step_q == 4'd15) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          if (cnt_q == '0 || div_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
            if (cnt_q == '0) begin
              led_q   <= '0;
              alert_q <= 1'b1;
            end else begin
              led_q   <= avg_d[7:0];
              alert_q <= alert_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.led_output_o = led_q;
  assign bus.alert_o      = alert_q;

endmodule

// File: tb/tb_temperature_scan_ctrl.sv
// Directed bench for temperature_scan_ctrl: latency, rounding, alert
// limits, ignored restart, input snapshot and mid-run reset.
module tb_temperature_scan_ctrl;
  import temp_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  temperature_scan_ctrl_if bus ();

  temperature_scan_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs 40 edges after the accepting edge. restart_at/rst_at/mut_at
  // name the edge on which that disturbance is presented (-1 = none).
  task automatic run(
    input  logic [BUS_W-1:0]     data,
    input  logic [N_SENSORS-1:0] en,
    input  int                   restart_at,
    input  int                   rst_at,
    input  int                   mut_at,
    input  logic [BUS_W-1:0]     mut_data,
    output int                   lat,
    output int                   ndone,
    output int                   busy0
  );
    lat   = -1;
    ndone = 0;
    bus.sensors_data_i = data;
    bus.sensors_en_i   = en;
    bus.start_i        = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    busy0 = int'(bus.busy_o);
    for (int k = 1; k <= 40; k++) begin
      if (k == restart_at) bus.start_i = 1'b1;
      if (k == rst_at) rst = 1'b1;
      if (k == mut_at) bus.sensors_data_i = mut_data;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      rst = 1'b0;
      if (bus.done_o) begin
        ndone++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  int lat, nd, b0;

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.sensors_data_i = '0;
    bus.sensors_en_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_led", int'(bus.led_output_o), 0);
    check("rst_alert", int'(bus.alert_o), 0);

    run({8'd24, 8'd23, 8'd22, 8'd21, 8'd20}, 5'b11111,
        -1, -1, -1, '0, lat, nd, b0);
    check("all_busy0", b0, 1);
    check("all_lat", lat, 22);
    check("all_ndone", nd, 1);
    check("all_led", int'(bus.led_output_o), 22);
    check("all_alert", int'(bus.alert_o), 0);
    check("all_busy_end", int'(bus.busy_o), 0);

    run({8'd99, 8'd99, 8'd21, 8'd21, 8'd20}, 5'b00111,
        -1, -1, -1, '0, lat, nd, b0);
    check("rnd_up_lat", lat, 22);
    check("rnd_up_led", int'(bus.led_output_o), 21);
    check("rnd_up_alert", int'(bus.alert_o), 0);

    run({8'd21, 8'd90, 8'd20, 8'd90, 8'd20}, 5'b10101,
        -1, -1, -1, '0, lat, nd, b0);
    check("rnd_dn_led", int'(bus.led_output_o), 20);
    check("rnd_dn_alert", int'(bus.alert_o), 0);

    run({8'd0, 8'd0, 8'd0, 8'd26, 8'd27}, 5'b00011,
        -1, -1, -1, '0, lat, nd, b0);
    check("hi_edge_led", int'(bus.led_output_o), 27);
    check("hi_edge_alert", int'(bus.alert_o), 1);

    run({8'd26, 8'd26, 8'd26, 8'd26, 8'd26}, 5'b11111,
        -1, -1, -1, '0, lat, nd, b0);
    check("max_in_led", int'(bus.led_output_o), 26);
    check("max_in_alert", int'(bus.alert_o), 0);

    run({8'd20, 8'd20, 8'd20, 8'd20, 8'd20}, 5'b00000,
        -1, -1, -1, '0, lat, nd, b0);
    check("zero_lat", lat, 6);
    check("zero_ndone", nd, 1);
    check("zero_led", int'(bus.led_output_o), 0);
    check("zero_alert", int'(bus.alert_o), 1);

    run({8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 5'b11111,
        -1, -1, -1, '0, lat, nd, b0);
    check("max_led", int'(bus.led_output_o), 255);
    check("max_alert", int'(bus.alert_o), 1);

    run({8'd50, 8'd50, 8'd50, 8'd50, 8'd18}, 5'b00001,
        -1, -1, -1, '0, lat, nd, b0);
    check("low_led", int'(bus.led_output_o), 18);
    check("low_alert", int'(bus.alert_o), 1);

    run({8'd24, 8'd23, 8'd22, 8'd21, 8'd20}, 5'b11111,
        10, -1, -1, '0, lat, nd, b0);
    check("restart_lat", lat, 22);
    check("restart_ndone", nd, 1);
    check("restart_led", int'(bus.led_output_o), 22);

    run({8'd20, 8'd20, 8'd20, 8'd20, 8'd20}, 5'b11111,
        -1, -1, 2, {8'd90, 8'd90, 8'd90, 8'd90, 8'd90},
        lat, nd, b0);
    check("snap_led", int'(bus.led_output_o), 20);
    check("snap_alert", int'(bus.alert_o), 0);

    run({8'd255, 8'd255, 8'd255, 8'd255, 8'd255}, 5'b11111,
        -1, -1, -1, '0, lat, nd, b0);
    check("pre_rst_led", int'(bus.led_output_o), 255);

    run({8'd24, 8'd23, 8'd22, 8'd21, 8'd20}, 5'b11111,
        -1, 11, -1, '0, lat, nd, b0);
    check("rst_div_ndone", nd, 0);
    check("rst_div_busy", int'(bus.busy_o), 0);
    check("rst_div_led", int'(bus.led_output_o), 0);
    check("rst_div_alert", int'(bus.alert_o), 0);

    run({8'd24, 8'd23, 8'd22, 8'd21, 8'd20}, 5'b11111,
        -1, -1, -1, '0, lat, nd, b0);
    check("post_rst_lat", lat, 22);
    check("post_rst_led", int'(bus.led_output_o), 22);
    check("post_rst_alert", int'(bus.alert_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/temperature_scan_ctrl.md
# temperature_scan_ctrl

Sequential controller for the temperature averaging path: on a start request it snapshots the sensor bus, accumulates enabled readings one sensor per cycle, and drives a shared 16-cycle restoring divider. It rounds the quotient and produces the averaged LED value plus an out-of-range alert with a done pulse. It replaces the combinational sum/divide/display chain for designs where area matters more than latency.

## Interface
- N_SENSORS, 5, number of sensor slots
- DATA_W, 8, bits per sensor reading
- TEMP_MIN, 19, lowest in-range average
- TEMP_MAX, 26, highest in-range average
- clk_i  input  1  rising-edge clock
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request a measurement; accepted only when busy_o=0
- sensors_data_i  input  N_SENSORS*DATA_W  reading i on bits [DATA_W*i+DATA_W-1 : DATA_W*i], unsigned
- sensors_en_i  input  N_SENSORS  bit i enables sensor i
- busy_o  output  1  high from the accepting edge until done
- done_o  output  1  one-cycle pulse; results valid from this cycle
- led_output_o  output  8  rounded average, held until the next done
- alert_o  output  1  out-of-range or no active sensor, held until the next done

## Operation
- States: IDLE, SCAN, DIV, FIN.
- IDLE: if start_i=1, latch sensors_data_i and sensors_en_i, clear sum (16 b) and count (8 b), set idx=0, and go to SCAN. Otherwise remain in IDLE.
- SCAN: one sensor per cycle. If enable bit idx is set, add the zero-extended reading to sum and increment count. After idx=N_SENSORS-1, go to DIV if count≠0, otherwise go to FIN.
- DIV: restoring division of sum by the zero-extended count, one quotient bit per cycle, MSB first, 16 cycles. Produces Q (16 b) and R (16 b) in seq_divider.
- FIN: compute avg = Q + (2R ≥ count ? 1 : 0).
  - led_output_o = avg[7:0]; the maximum average is 255, so there is no overflow.
  - alert_o = (count==0) | (avg<TEMP_MIN) | (avg>TEMP_MAX).
  - If count==0: led_output_o=0 and alert_o=1.
  - Assert done_o and return to IDLE.
- start_i while busy_o=1 is ignored. It is not queued.
- Input changes after the accepting edge do not affect the result.
- start_i held high gives back-to-back runs. A new run can be accepted in the done_o cycle, since the state is IDLE then.

## Timing
- Reset values: busy_o=0, done_o=0, led_output_o=0, alert_o=0, state IDLE, all internal registers 0.
- rst_i in any state aborts the run on that edge: no done_o, and outputs are reset.
- Let edge 0 be the start-accepting edge.
  - busy_o=1 after edge 0.
  - SCAN covers edges 1..N_SENSORS.
  - DIV covers the next 16 edges.
  - FIN is sampled on edge N_SENSORS+17 (22 for defaults).
  - done_o, led_output_o and alert_o update after edge 22. busy_o=0 from the same cycle.
- Zero-sensor run: done after edge N_SENSORS+1 (6).
- Latency is fixed and independent of the data, apart from the zero-sensor case.

## Structure
- Shared package temp_pkg: N_SENSORS, DATA_W, TEMP_MIN, TEMP_MAX, SUM_W=16, and the state enum {IDLE, SCAN, DIV, FIN}.
- Sub-module seq_divider (16-bit restoring divider):
  - inputs: load, dividend, divisor.
  - outputs: quotient, remainder, ready after 16 cycles.
  - It never sees a zero divisor.
- The FSM, accumulator, rounding and alert logic live in temperature_scan_ctrl.

## Test plan
- All enabled, readings 20,21,22,23,24 (sum 110), start -> done_o after edge 22, led_output_o=22, alert_o=0.
- en=5'b00111, readings 20,21,21 (sum 62, Q=20, R=2) -> rounds up, led_output_o=21, alert_o=0.
- en=0 -> done_o after edge 6, led_output_o=0, alert_o=1.
- All enabled, all readings 255 -> led_output_o=255, alert_o=1. en=5'b00001 with reading 18 -> 18, alert_o=1.
- Pulse start_i again at edge 10 of a run -> ignored, exactly one done_o.
- Change sensors_data_i mid-run -> result reflects the snapshot.
- Assert rst_i during DIV -> outputs return to 0, no done_o. The next start works normally.
